ntt_sched_ctrl: RTL and testbench

- Sequencing controller for the 8-butterfly-unit NTT core. Polynomial: 256 coefficients stored as 16 rows of 16×12-bit coefficients (192-bit beats).
- Accepts a start request and direction, then walks the core through four phases:
  - LOAD: 16 input beats.
  - COMPUTE: 7 butterfly layers.
  - SCALE: optional inverse-NTT scaling pass.
  - OUT: 16 output beats.
- Generates memory addresses, BU enables, zeta ROM base addresses and delayed write-back strobes. Contains no datapath arithmetic.

---
 rtl/ntt_sched_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_ntt_sched_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sched_ctrl.sv
// ntt_sched_ctrl: phase sequencer for the 8-BU NTT core (load, butterfly layers, scale, out).
// Drives memory addresses, BU enables, zeta ROM bases and latency-matched write-back strobes.
module ntt_sched_ctrl #(
    parameter int ROWS      = 16,
    parameter int LAYERS    = 7,
    parameter int RD_LAT    = 1,
    parameter int BU_LAT    = 4,
    parameter int ADDR_ZETA = 7
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        is_ntt_i,
    input  logic                        valid_input_i,
    output logic                        ld_we_o,
    output logic [$clog2(ROWS)-1:0]     ld_addr_o,
    output logic                        rd_en_o,
    output logic [$clog2(ROWS)-1:0]     rd_addr_o,
    output logic                        bu_en_o,
    output logic [1:0]                  mode_o,
    output logic [$clog2(LAYERS)-1:0]   layer_o,
    output logic [ADDR_ZETA-1:0]        zeta_base_o,
    output logic                        wb_we_o,
    output logic [$clog2(ROWS)-1:0]     wb_addr_o,
    output logic                        dout_valid_o,
    output logic [$clog2(ROWS)-1:0]     dout_addr_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int CW       = $clog2(ROWS);
    localparam int LW       = $clog2(LAYERS);
    localparam int WB_DEPTH = RD_LAT + BU_LAT;

    localparam logic [1:0] MODE_CT    = 2'd0;
    localparam logic [1:0] MODE_GS    = 2'd1;
    localparam logic [1:0] MODE_SCALE = 2'd2;
    localparam logic [1:0] MODE_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_SCALE, S_OUT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       layer_q, layer_d;
    logic                inv_q, inv_d;
    logic                scale_q, scale_d;
    logic                issued_q, issued_d;

    logic [ADDR_ZETA-1:0] cnt_ext, grp, pow, zeta_calc, zeta_iss;
    logic                 wb_in, last_layer, layer_mode_gs;

    logic [RD_LAT-1:0]                 rp_en, rp_out;
    logic [RD_LAT-1:0][CW-1:0]         rp_addr;
    logic [RD_LAT-1:0][ADDR_ZETA-1:0]  rp_zeta;
    logic [WB_DEPTH-1:0]               wp_we;
    logic [WB_DEPTH-1:0][CW-1:0]       wp_addr;

    // Twiddle grouping: early layers share a zeta across 2^(4-l) rows, late layers split rows.
    always_comb begin
        cnt_ext = ADDR_ZETA'(cnt_q);
        if (int'(layer_q) <= CW) grp = cnt_ext >> (CW - int'(layer_q));
        else                     grp = cnt_ext << (int'(layer_q) - CW);
        pow       = ADDR_ZETA'(1) << layer_q;
        zeta_calc = inv_q ? ((pow << 1) - ADDR_ZETA'(1) - grp) : (pow + grp);
    end

    assign last_layer    = inv_q ? (layer_q == '0) : (layer_q == LW'(LAYERS - 1));
    assign layer_mode_gs = inv_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        layer_d   = layer_q;
        inv_d     = inv_q;
        scale_d   = scale_q;
        issued_d  = issued_q;
        ld_we_o   = 1'b0;
        ld_addr_o = '0;
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        mode_o    = MODE_IDLE;
        zeta_iss  = '0;
        wb_in     = 1'b0;
        done_o    = 1'b0;
        busy_o    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    inv_d    = ~is_ntt_i;
                    cnt_d    = '0;
                    scale_d  = 1'b0;
                    issued_d = 1'b0;
                    layer_d  = is_ntt_i ? '0 : LW'(LAYERS - 1);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_we_o   = valid_input_i;
                ld_addr_o = cnt_q;
                if (valid_input_i) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(ROWS - 1)) state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cnt_q;
                mode_o    = layer_mode_gs ? MODE_GS : MODE_CT;
                zeta_iss  = zeta_calc;
                wb_in     = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(ROWS - 1)) state_d = S_DRAIN;
            end
            // Wait out the full read+BU latency so the next pass never reads a stale row.
            S_DRAIN: begin
                mode_o = scale_q ? MODE_SCALE : (layer_mode_gs ? MODE_GS : MODE_CT);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WB_DEPTH - 1)) begin
                    cnt_d = '0;
                    if (scale_q) begin
                        state_d = S_OUT;
                    end else if (last_layer) begin
                        if (inv_q) begin
                            scale_d = 1'b1;
                            state_d = S_SCALE;
                        end else begin
                            state_d = S_OUT;
                        end
                    end else begin
                        layer_d = inv_q ? (layer_q - LW'(1)) : (layer_q + LW'(1));
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_SCALE: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cnt_q;
                mode_o    = MODE_SCALE;
                wb_in     = 1'b1;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(ROWS - 1)) state_d = S_DRAIN;
            end
            S_OUT: begin
                if (!issued_q) begin
                    rd_en_o   = 1'b1;
                    rd_addr_o = cnt_q;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == CW'(ROWS - 1)) issued_d = 1'b1;
                end
                if (dout_valid_o && (dout_addr_o == CW'(ROWS - 1))) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-latency pipe feeds the BU and output side; the longer pipe times the write-back.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            layer_q  <= '0;
            inv_q    <= 1'b0;
            scale_q  <= 1'b0;
            issued_q <= 1'b0;
            rp_en    <= '0;
            rp_out   <= '0;
            rp_addr  <= '0;
            rp_zeta  <= '0;
            wp_we    <= '0;
            wp_addr  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            layer_q    <= layer_d;
            inv_q      <= inv_d;
            scale_q    <= scale_d;
            issued_q   <= issued_d;
            rp_en[0]   <= rd_en_o;
            rp_out[0]  <= rd_en_o && (state_q == S_OUT);
            rp_addr[0] <= rd_addr_o;
            rp_zeta[0] <= zeta_iss;
            for (int i = 1; i < RD_LAT; i++) begin
                rp_en[i]   <= rp_en[i-1];
                rp_out[i]  <= rp_out[i-1];
                rp_addr[i] <= rp_addr[i-1];
                rp_zeta[i] <= rp_zeta[i-1];
            end
            wp_we[0]   <= wb_in;
            wp_addr[0] <= rd_addr_o;
            for (int i = 1; i < WB_DEPTH; i++) begin
                wp_we[i]   <= wp_we[i-1];
                wp_addr[i] <= wp_addr[i-1];
            end
        end
    end

    assign bu_en_o      = rp_en[RD_LAT-1];
    assign zeta_base_o  = rp_zeta[RD_LAT-1];
    assign dout_valid_o = rp_out[RD_LAT-1];
    assign dout_addr_o  = dout_valid_o ? rp_addr[RD_LAT-1] : '0;
    assign wb_we_o      = wp_we[WB_DEPTH-1];
    assign wb_addr_o    = wp_addr[WB_DEPTH-1];
    assign layer_o      = layer_q;

endmodule

// File: tb/tb_ntt_sched_ctrl.sv
// tb_ntt_sched_ctrl: directed bench for the NTT scheduling controller.
// Walks forward, inverse, gapped-load and mid-run reset scenarios cycle by cycle.
module tb_ntt_sched_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni, start_i, is_ntt_i, valid_input_i;
    logic       ld_we_o, rd_en_o, bu_en_o, wb_we_o, dout_valid_o, busy_o, done_o;
    logic [3:0] ld_addr_o, rd_addr_o, wb_addr_o, dout_addr_o;
    logic [1:0] mode_o;
    logic [2:0] layer_o;
    logic [6:0] zeta_base_o;

    int errors = 0;
    int checks = 0;

    ntt_sched_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .is_ntt_i(is_ntt_i),
        .valid_input_i(valid_input_i), .ld_we_o(ld_we_o), .ld_addr_o(ld_addr_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .bu_en_o(bu_en_o), .mode_o(mode_o),
        .layer_o(layer_o), .zeta_base_o(zeta_base_o), .wb_we_o(wb_we_o),
        .wb_addr_o(wb_addr_o), .dout_valid_o(dout_valid_o), .dout_addr_o(dout_addr_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    wire [34:0] all_out = {ld_we_o, ld_addr_o, rd_en_o, rd_addr_o, bu_en_o, mode_o, layer_o,
                           zeta_base_o, wb_we_o, wb_addr_o, dout_valid_o, dout_addr_o, busy_o, done_o};
    wire [34:0] idle_out = {1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd3, 3'd0,
                            7'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0};

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    function automatic int zeta_ref(input int l, input int j, input bit fwd);
        int g;
        g = (l <= 4) ? (j >> (4 - l)) : (j << (l - 4));
        return fwd ? ((2 ** l) + g) : ((2 ** (l + 1)) - 1 - g);
    endfunction

    // Expected issue-side behaviour at cycle c, counted from the cycle of the last load beat (c=0).
    function automatic void exp_issue(input bit fwd, input int c, output bit en, output bit o,
                                      output int addr, output int layer, output int mode,
                                      output int zeta);
        int comp_end, p, r;
        en = 1'b0; o = 1'b0; addr = 0; layer = 0; mode = 3; zeta = 0;
        comp_end = fwd ? 147 : 168;
        if (c >= 1 && c <= comp_end) begin
            p = (c - 1) / 21;
            r = (c - 1) % 21;
            if (r < 16) begin
                en = 1'b1;
                addr = r;
                if (p < 7) begin
                    layer = fwd ? p : 6 - p;
                    mode  = fwd ? 0 : 1;
                    zeta  = zeta_ref(layer, r, fwd);
                end else begin
                    mode = 2;
                end
            end
        end else if (c > comp_end && c <= comp_end + 16) begin
            en = 1'b1;
            o = 1'b1;
            addr = c - comp_end - 1;
        end
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; is_ntt_i = 1'b0; valid_input_i = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (all_out !== idle_out)
            begin errors++; $display("[TB] FAIL reset_outputs got %h want %h", all_out, idle_out); end
        start_i = 1'b1;
        tick();
        #1;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_prio_busy got %0b want 0", busy_o); end
        start_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        #1;
        checks++;
        if (all_out !== idle_out)
            begin errors++; $display("[TB] FAIL idle_outputs got %h want %h", all_out, idle_out); end
        tick();
    endtask

    task automatic test_transform(input bit fwd, input int gap, input string name);
        int pulses, end_c, a, l, m, z;
        bit en, o;
        pulses = 0;
        end_c = (fwd ? 147 : 168) + 17 + 1;
        start_i = 1'b1; is_ntt_i = fwd;
        tick();
        start_i = 1'b0; is_ntt_i = ~fwd;
        for (int b = 0; b < 16; b++) begin
            for (int g = 1; g < gap; g++) begin
                valid_input_i = 1'b0;
                start_i = (g == 1);
                #1;
                if (ld_we_o === 1'b1) pulses++;
                checks++;
                if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL %s load_busy got %0b want 1", name, busy_o); end
                tick();
            end
            valid_input_i = 1'b1;
            start_i = 1'b0;
            #1;
            if (ld_we_o === 1'b1) pulses++;
            checks++;
            if (ld_addr_o !== 4'(b))
                begin errors++; $display("[TB] FAIL %s ld_addr beat %0d got %0d want %0d", name, b, ld_addr_o, b); end
            tick();
        end
        valid_input_i = 1'b0;
        checks++;
        if (pulses != 16) begin errors++; $display("[TB] FAIL %s ld_we_pulses got %0d want 16", name, pulses); end

        for (int c = 1; c <= end_c + 1; c++) begin
            #1;
            exp_issue(fwd, c, en, o, a, l, m, z);
            checks++;
            if (rd_en_o !== en) begin errors++; $display("[TB] FAIL %s rd_en c=%0d got %0b want %0b", name, c, rd_en_o, en); end
            if (en) begin
                checks++;
                if (rd_addr_o !== 4'(a)) begin errors++; $display("[TB] FAIL %s rd_addr c=%0d got %0d want %0d", name, c, rd_addr_o, a); end
                checks++;
                if (mode_o !== 2'(m)) begin errors++; $display("[TB] FAIL %s mode c=%0d got %0d want %0d", name, c, mode_o, m); end
                if (!o && m != 2) begin
                    checks++;
                    if (layer_o !== 3'(l)) begin errors++; $display("[TB] FAIL %s layer c=%0d got %0d want %0d", name, c, layer_o, l); end
                end
            end
            exp_issue(fwd, c - 1, en, o, a, l, m, z);
            checks++;
            if (bu_en_o !== en) begin errors++; $display("[TB] FAIL %s bu_en c=%0d got %0b want %0b", name, c, bu_en_o, en); end
            if (en && !o) begin
                checks++;
                if (zeta_base_o !== 7'(z)) begin errors++; $display("[TB] FAIL %s zeta c=%0d got %0d want %0d", name, c, zeta_base_o, z); end
            end
            checks++;
            if (dout_valid_o !== (en && o)) begin errors++; $display("[TB] FAIL %s dout_valid c=%0d got %0b want %0b", name, c, dout_valid_o, en && o); end
            if (en && o) begin
                checks++;
                if (dout_addr_o !== 4'(a)) begin errors++; $display("[TB] FAIL %s dout_addr c=%0d got %0d want %0d", name, c, dout_addr_o, a); end
            end
            exp_issue(fwd, c - 5, en, o, a, l, m, z);
            checks++;
            if (wb_we_o !== (en && !o)) begin errors++; $display("[TB] FAIL %s wb_we c=%0d got %0b want %0b", name, c, wb_we_o, en && !o); end
            if (en && !o) begin
                checks++;
                if (wb_addr_o !== 4'(a)) begin errors++; $display("[TB] FAIL %s wb_addr c=%0d got %0d want %0d", name, c, wb_addr_o, a); end
            end
            checks++;
            if (done_o !== (c == end_c)) begin errors++; $display("[TB] FAIL %s done c=%0d got %0b want %0b", name, c, done_o, c == end_c); end
            checks++;
            if (busy_o !== (c <= end_c)) begin errors++; $display("[TB] FAIL %s busy c=%0d got %0b want %0b", name, c, busy_o, c <= end_c); end
            if ((fwd && c == 2) || (!fwd && c == 137)) begin
                checks++;
                if (zeta_base_o !== 7'd1) begin errors++; $display("[TB] FAIL %s zeta_spot1 c=%0d got %0d want 1", name, c, zeta_base_o); end
            end
            if (fwd && c == 91) begin
                checks++;
                if (zeta_base_o !== 7'd21) begin errors++; $display("[TB] FAIL %s zeta_l4_op5 got %0d want 21", name, zeta_base_o); end
            end
            if (fwd && c == 131) begin
                checks++;
                if (zeta_base_o !== 7'd76) begin errors++; $display("[TB] FAIL %s zeta_l6_op3 got %0d want 76", name, zeta_base_o); end
            end
            if (!fwd && c == 2) begin
                checks++;
                if (zeta_base_o !== 7'd127) begin errors++; $display("[TB] FAIL %s zeta_inv_l6_op0 got %0d want 127", name, zeta_base_o); end
            end
            if (!fwd && c == 148) begin
                checks++;
                if (mode_o !== 2'd2) begin errors++; $display("[TB] FAIL %s scale_mode got %0d want 2", name, mode_o); end
            end
            start_i = (c == 50) || (c == 120);
            tick();
        end
        start_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        start_i = 1'b1; is_ntt_i = 1'b1;
        tick();
        start_i = 1'b0;
        valid_input_i = 1'b1;
        for (int b = 0; b < 16; b++) tick();
        valid_input_i = 1'b0;
        for (int c = 1; c < 71; c++) tick();
        #1;
        checks++;
        if (rd_en_o !== 1'b1 || layer_o !== 3'd3)
            begin errors++; $display("[TB] FAIL midrst_pre got en=%0b layer=%0d want en=1 layer=3", rd_en_o, layer_o); end
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (all_out !== idle_out)
            begin errors++; $display("[TB] FAIL midrst_outputs got %h want %h", all_out, idle_out); end
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            checks++;
            if (wb_we_o !== 1'b0 || busy_o !== 1'b0)
                begin errors++; $display("[TB] FAIL midrst_quiet c=%0d got wb=%0b busy=%0b want 0 0", c, wb_we_o, busy_o); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_transform(1'b1, 1, "fwd");
        test_transform(1'b0, 1, "inv");
        test_transform(1'b1, 8, "gapped");
        test_mid_reset();
        test_transform(1'b1, 1, "post_reset");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
